// File: rtl/mac_pkg.sv
// Shared constants, stage record and saturation limits for the pipelined MAC.
// Limits are returned in a wide word; callers slice them to their accumulator width.
package mac_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ACC_W   = 24;
    localparam int DEF_CSA_BLK = 4;
    localparam int STG_W       = 64;

    typedef struct packed {
        logic [STG_W-1:0] dat;
        logic             last;
        logic             vld;
    } stage_t;

    typedef enum logic {
        S3_ACCUM = 1'b0,
        S3_HOLD  = 1'b1
    } s3_state_e;

    function automatic logic [STG_W-1:0] sat_hi(input int w, input bit sgn);
        logic [STG_W-1:0] one;
        one = {{(STG_W-1){1'b0}}, 1'b1};
        sat_hi = sgn ? ((one << (w - 1)) - one) : ((one << w) - one);
    endfunction

    function automatic logic [STG_W-1:0] sat_lo(input int w, input bit sgn);
        sat_lo = sgn ? ~sat_hi(w, 1'b1) : '0;
    endfunction

endpackage

// File: rtl/mac_csa_pipe_csa_add.sv
// Carry-select adder: every block precomputes its sum for carry-in 0 and 1,
// and the carry rippling between blocks only drives the select muxes.
module csa_add #(
    parameter int W   = 25,
    parameter int BLK = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    localparam int NB = (W + BLK - 1) / BLK;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        localparam int LO = k * BLK;
        localparam int BW = ((W - LO) < BLK) ? (W - LO) : BLK;

        logic [BW:0] s0;
        logic [BW:0] s1;
        logic        ci;
        logic        co;

        if (k == 0) begin : g_c0
            assign ci = cin_i;
        end else begin : g_cn
            assign ci = g_blk[k-1].co;
        end

        assign s0 = {1'b0, a_i[LO +: BW]} + {1'b0, b_i[LO +: BW]};
        assign s1 = {1'b0, a_i[LO +: BW]} + {1'b0, b_i[LO +: BW]} + {{BW{1'b0}}, 1'b1};

        assign sum_o[LO +: BW] = ci ? s1[BW-1:0] : s0[BW-1:0];
        assign co              = ci ? s1[BW]     : s0[BW];
    end

    assign cout_o = g_blk[NB-1].co;

endmodule

// File: rtl/mac_csa_pipe.sv
// Pipelined saturating multiply-accumulate: one dot product per last-flagged vector.
// Last pair accepted at edge T shows on the output after edge T+3; a held output stalls every stage.
module mac_csa_pipe
    import mac_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int SIGNED  = 1,
    parameter int CSA_BLK = DEF_CSA_BLK
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic              ovf_o
);

    localparam bit SGN = (SIGNED != 0);
    localparam int PW  = 2 * DATA_W;
    localparam int SW  = ACC_W + 1;
    localparam logic [STG_W-1:0] HI_L = sat_hi(ACC_W, SGN);
    localparam logic [STG_W-1:0] LO_L = sat_lo(ACC_W, SGN);

    logic      en;
    logic      load;
    s3_state_e state_q;
    s3_state_e state_d;

    // S1: operand capture
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              s1_last_q;
    logic              s1_vld_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_q       <= '0;
            b_q       <= '0;
            s1_last_q <= 1'b0;
            s1_vld_q  <= 1'b0;
        end else if (en) begin
            s1_vld_q <= in_valid_i;
            if (in_valid_i) begin
                a_q       <= a_i;
                b_q       <= b_i;
                s1_last_q <= in_last_i;
            end
        end
    end

    // S2: the low PW bits of a product of extended operands are the exact product in either mode
    logic [PW-1:0]    a_x;
    logic [PW-1:0]    b_x;
    logic [PW-1:0]    prod;
    logic [STG_W-1:0] prod_ext;
    stage_t           s2_q;

    assign a_x      = {{DATA_W{SGN & a_q[DATA_W-1]}}, a_q};
    assign b_x      = {{DATA_W{SGN & b_q[DATA_W-1]}}, b_q};
    assign prod     = a_x * b_x;
    assign prod_ext = {{(STG_W-PW){SGN & prod[PW-1]}}, prod};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_q <= '0;
        end else if (en) begin
            s2_q.vld  <= s1_vld_q;
            s2_q.last <= s1_last_q;
            if (s1_vld_q) begin
                s2_q.dat <= prod_ext;
            end
        end
    end

    // S3: accumulate one bit wider than the accumulator so overflow is visible
    logic [ACC_W-1:0] acc_q;
    logic             sticky_q;
    logic [ACC_W-1:0] res_q;
    logic             res_ovf_q;
    logic             res_vld_q;
    logic [SW-1:0]    acc_x;
    logic [SW-1:0]    add_b;
    logic [SW-1:0]    sum;
    logic             add_co;
    logic             term_ovf;
    logic [ACC_W-1:0] sat_sum;
    logic             unused_bits;

    assign acc_x       = {SGN & acc_q[ACC_W-1], acc_q};
    assign add_b       = s2_q.dat[SW-1:0];
    assign unused_bits = ^{add_co, s2_q.dat[STG_W-1:SW]};

    csa_add #(
        .W   (SW),
        .BLK (CSA_BLK)
    ) u_acc_add (
        .a_i    (acc_x),
        .b_i    (add_b),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (add_co)
    );

    always_comb begin
        term_ovf = SGN ? (sum[SW-1] ^ sum[SW-2]) : sum[SW-1];
        sat_sum  = sum[ACC_W-1:0];
        if (term_ovf) begin
            sat_sum = (SGN && sum[SW-1]) ? LO_L[ACC_W-1:0] : HI_L[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q     <= '0;
            sticky_q  <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
            res_vld_q <= 1'b0;
        end else if (en) begin
            res_vld_q <= s2_q.vld & s2_q.last;
            if (s2_q.vld) begin
                if (s2_q.last) begin
                    res_q     <= sat_sum;
                    res_ovf_q <= sticky_q | term_ovf;
                    acc_q     <= '0;
                    sticky_q  <= 1'b0;
                end else begin
                    acc_q    <= sat_sum;
                    sticky_q <= sticky_q | term_ovf;
                end
            end
        end
    end

    // Output register and its full/empty state
    logic [ACC_W-1:0] out_q;
    logic             out_ovf_q;

    assign load = en & res_vld_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_q     <= '0;
            out_ovf_q <= 1'b0;
        end else if (load) begin
            out_q     <= res_q;
            out_ovf_q <= res_ovf_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S3_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S3_ACCUM: if (load) state_d = S3_HOLD;
            S3_HOLD:  if (out_ready_i && !load) state_d = S3_ACCUM;
            default:  state_d = S3_ACCUM;
        endcase
    end

    always_comb begin
        out_valid_o = (state_q == S3_HOLD);
        en          = (state_q == S3_ACCUM) || out_ready_i;
    end

    assign in_ready_o = en;
    assign acc_o      = out_q;
    assign ovf_o      = out_ovf_q;

endmodule
